// File: rtl/vector_item_serializer.sv
// -----------------------------------------------------------------------------
// vector_item_serializer
//   Captures an I-item vector on start and walks item addresses 0..len_q-1
//   through an external (combinational) item extractor, streaming each
//   returned item on a valid/ready interface with a last-item marker.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | no stream; waits for start, captured vector held for extractor
//   RUN    | offering item at ext_address; advances on each accepted beat
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               capture vec_in/len and begin streaming (IDLE only)
//   vec_in [I*L]        source vector, item k = vec_in[k*L +: L]
//   len [5]             items to stream; 0 or >I means I
//   abort               synchronous cancel of a running stream
//   ext_vector [I*L]    captured vector to extractor
//   ext_address [5]     current item address to extractor
//   ext_item [L]        item returned by extractor
//   out_valid/out_ready stream handshake
//   out_item [L]        streamed item (pass-through of ext_item)
//   out_last            marks final item of the stream
//   busy                high while streaming
//   done                one-cycle pulse after final beat or abort
// -----------------------------------------------------------------------------
module vector_item_serializer #(
  parameter int I = 20,
  parameter int L = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [I*L-1:0] vec_in,
  input  logic [4:0]     len,
  input  logic           abort,
  output logic [I*L-1:0] ext_vector,
  output logic [4:0]     ext_address,
  input  logic [L-1:0]   ext_item,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [L-1:0]   out_item,
  output logic           out_last,
  output logic           busy,
  output logic           done
);

  // len_q needs 6 bits so that I = 32 is representable.
  localparam logic [5:0] I_W = 6'(I);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_count;
  logic [5:0]  r_len;
  logic        r_done;
  logic        w_done_nxt;
  logic        w_run;
  logic        w_xfer;
  logic        w_last;
  logic [5:0]  w_len_eff;

  assign w_run     = (r_state == S_RUN);
  assign w_len_eff = ((len == 5'd0) || ({1'b0, len} > I_W)) ? I_W : {1'b0, len};
  assign w_last    = w_run && ({1'b0, r_count} == (r_len - 6'd1));
  assign w_xfer    = w_run && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Abort wins over a simultaneous transfer.
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_xfer && w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ext_vector is only rewritten by an accepted start, so the extractor
  // keeps a defined input after the stream finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_vector <= '0;
      r_count    <= 5'd0;
      r_len      <= 6'd0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        ext_vector <= vec_in;
        r_count    <= 5'd0;
        r_len      <= w_len_eff;
      end
    end else begin
      if (abort || (w_xfer && w_last)) begin
        r_count <= 5'd0;
      end else if (w_xfer) begin
        r_count <= r_count + 5'd1;
      end
    end
  end

  assign ext_address = r_count;
  assign out_valid   = w_run;
  assign busy        = w_run;
  assign out_last    = w_last;
  assign out_item    = ext_item;
  assign done        = r_done;

endmodule

// File: tb/tb_vector_item_serializer.sv
// -----------------------------------------------------------------------------
// tb_vector_item_serializer
//   Directed scenarios plus randomized traffic. The reference model keeps the
//   pending stream as a queue of items captured at start; each accepted beat
//   pops the head. The extractor is modelled as a plain item select.
// -----------------------------------------------------------------------------
module tb_vector_item_serializer;
  localparam int I = 20;
  localparam int L = 32;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [I*L-1:0] vec_in;
  logic [4:0]     len;
  logic           abort;
  logic [I*L-1:0] ext_vector;
  logic [4:0]     ext_address;
  logic [L-1:0]   ext_item;
  logic           out_valid;
  logic           out_ready;
  logic [L-1:0]   out_item;
  logic           out_last;
  logic           busy;
  logic           done;

  vector_item_serializer #(.I(I), .L(L)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .vec_in      (vec_in),
    .len         (len),
    .abort       (abort),
    .ext_vector  (ext_vector),
    .ext_address (ext_address),
    .ext_item    (ext_item),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_item    (out_item),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  // extractor stand-in
  assign ext_item = (int'(ext_address) < I) ? ext_vector[int'(ext_address)*L +: L] : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt;

  // reference model state
  logic [I*L-1:0] m_vec;
  logic [L-1:0]   m_q[$];
  bit             m_run;
  bit             m_done;
  int             m_idx;

  task automatic chk(input string tag, input logic [I*L-1:0] got, input logic [I*L-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vec  = '0;
    m_q.delete();
    m_run  = 1'b0;
    m_done = 1'b0;
    m_idx  = 0;
  endtask

  // One clock: compare outputs at negedge, advance the model with the inputs
  // as they stand, then return just after the rising edge.
  task automatic cycle();
    int n;
    @(negedge clk);
    chk("valid", out_valid, m_run);
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("ext_vector", ext_vector, m_vec);
    if (m_run) begin
      chk("item", out_item, m_q[0]);
      chk("last", out_last, m_q.size() == 1);
      chk("addr", ext_address, m_idx);
    end else begin
      chk("last_idle", out_last, 1'b0);
    end
    if (busy) busy_cnt++;
    m_done = 1'b0;
    if (rst_n) begin
      if (!m_run) begin
        if (start) begin
          n = (len == 0 || int'(len) > I) ? I : int'(len);
          m_q.delete();
          for (int k = 0; k < n; k++) m_q.push_back(vec_in[k*L +: L]);
          m_vec = vec_in;
          m_idx = 0;
          m_run = 1'b1;
        end
      end else if (abort) begin
        m_q.delete();
        m_run  = 1'b0;
        m_done = 1'b1;
        m_idx  = 0;
      end else if (out_ready) begin
        void'(m_q.pop_front());
        m_idx++;
        if (m_q.size() == 0) begin
          m_run  = 1'b0;
          m_done = 1'b1;
          m_idx  = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec();
    for (int k = 0; k < I; k++) vec_in[k*L +: L] = $urandom;
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_addr", ext_address, 5'd0);
    chk("rst_vec", ext_vector, '0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    len       = 5'd0;
    out_ready = 1'b0;
    vec_in    = '0;
    busy_cnt  = 0;
    model_reset();
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // full stream, len=0 -> 20 items
    for (int k = 0; k < I; k++) vec_in[k*L +: L] = 32'hA000_0000 + k;
    len = 5'd0; out_ready = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("first_item", out_item, 32'hA000_0000);
    busy_cnt = 0;
    repeat (22) cycle();
    chk("busy_cycles", busy_cnt, 20);

    // backpressure
    rand_vec(); len = 5'd4; out_ready = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    begin
      bit pat[7] = '{1, 0, 0, 1, 0, 1, 1};
      for (int p = 0; p < 7; p++) begin
        out_ready = pat[p];
        cycle();
      end
    end
    out_ready = 1'b1;
    repeat (2) cycle();

    // short and oversize lengths
    rand_vec(); len = 5'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("len1_last", out_last, 1'b1);
    repeat (3) cycle();
    rand_vec(); len = 5'd25; start = 1'b1;
    cycle();
    start = 1'b0;
    busy_cnt = 0;
    repeat (22) cycle();
    chk("len25_cycles", busy_cnt, 20);

    // abort on item 3, with start and vec_in churn during RUN
    rand_vec(); len = 5'd10; out_ready = 1'b1; start = 1'b1;
    cycle();
    repeat (3) begin
      rand_vec();
      cycle();
    end
    start = 1'b0;
    chk("abort_addr", ext_address, 5'd3);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    repeat (3) cycle();

    // back-to-back: new start in the done-pulse cycle
    rand_vec(); len = 5'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    chk("b2b_done_seen", done, 1'b1);
    rand_vec(); len = 5'd5; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (7) cycle();

    // async reset mid-RUN at count=7
    rand_vec(); len = 5'd0; out_ready = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (7) cycle();
    chk("pre_rst_addr", ext_address, 5'd7);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      start     = ($urandom_range(0, 3) == 0);
      len       = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 2) != 0);
      abort     = ($urandom_range(0, 15) == 0);
      rand_vec();
      cycle();
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (25) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vector_item_serializer.md
Name: vector_item_serializer

Overview:
- Upstream sequencer for the vector item extractor: captures a full I-item vector on `start`, then walks item addresses 0..len-1.
- Drives the extractor's `vector`/`address` inputs and takes the selected item back.
- Streams the items out one per accepted beat on a valid/ready interface, marking the final item.
- Used wherever a vector-register value must be consumed element-by-element (scalar writeback, memory store path).

Parameters:
- I, 20, number of items in the vector (max 32, address is 5 bits)
- L, 32, item length in bits

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to capture vec_in/len and begin streaming; honoured only in IDLE
- vec_in  input  I*L  source vector; item k = vec_in[k*L +: L]
- len  input  5  number of items to stream; 0 or >I means I
- abort  input  1  synchronous cancel of an in-progress stream
- ext_vector  output  I*L  captured vector, wired to extractor `vector`
- ext_address  output  5  current item address, wired to extractor `address`
- ext_item  input  L  item returned by extractor (combinational path)
- out_valid  output  1  out_item/out_last valid
- out_ready  input  1  downstream accepts beat when out_valid & out_ready
- out_item  output  L  streamed item (= ext_item)
- out_last  output  1  high with the final item of the stream
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after final beat accepted or abort

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ext_vector=0, ext_address=0, count=0, len_q=0, out_valid=0, out_last=0, busy=0, done=0. Release is synchronous to clk.
- States: IDLE, RUN.
- IDLE:
  - out_valid=0, busy=0.
  - On start=1: ext_vector<=vec_in; count<=0; len_q<=(len==0 || len>I) ? I : len; next state RUN.
  - First beat is offered in the cycle after start (latency 1).
- RUN:
  - busy=1, out_valid=1, ext_address=count, out_item=ext_item, out_last=(count==len_q-1).
  - Handshake: a beat transfers when out_valid & out_ready.
  - While out_ready=0: count, ext_vector and out_item hold stable. out_valid never drops until the beat is accepted or abort.
  - On transfer with out_last=0: count<=count+1.
  - On transfer with out_last=1: state<=IDLE; done pulses 1 the next cycle; count<=0.
- Abort:
  - abort=1 in RUN: state<=IDLE next cycle, no further beats, done pulses 1.
  - Abort has priority over a simultaneous transfer; that beat is still counted as accepted by downstream, but no further beats follow.
  - abort in IDLE: ignored.
- start while in RUN: ignored, with no effect on captured data.
- start in the same cycle as a done pulse (state already IDLE): accepted normally.
- Back-to-back throughput: 1 item/cycle with out_ready held high. Stream of len_q items takes len_q cycles in RUN.
- ext_vector is held after completion until the next start, so the extractor output remains defined.
- count never exceeds I-1; ext_address is never driven beyond I-1.
- No combinational path from out_ready to out_valid.
- Combinational paths from ext_item to out_item and from ext_address to ext_item are permitted.

Test Plan:
- Reset then idle: rst_n low mid-RUN (count=7) -> all outputs 0 immediately. After release, out_valid stays 0 until start.
- Full stream: vec_in item k = 32'hA000_0000+k, len=0, out_ready=1 -> 20 beats on consecutive cycles, items A0000000..A0000013. out_last only on beat 20; done one cycle later; busy high exactly 20 cycles.
- Backpressure: len=4, out_ready toggling 1,0,0,1,0,1,1 -> out_item stable while stalled. Exactly items 0..3 delivered in order; out_last with item 3.
- Short and oversize length: len=1 -> a single beat, out_last=1 with item 0. len=25 -> treated as 20 beats.
- Abort: len=10, abort on the cycle item 3 is offered with out_ready=1 -> no beat after 3, done pulse next cycle. A start during RUN is ignored and vec_in changes do not alter items.
- Back-to-back: start asserted in the done-pulse cycle with a new vector -> second stream begins the following cycle with the new item 0. No stale items.
